// File: rtl/uart_pkg.sv
// Shared UART constants: frame geometry, bit-timing helpers and the FSM state
// encoding used by both the receiver and the transmitter.
package uart_pkg;

  localparam int FrameWidth = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int ticks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  function automatic int half_bit(input int clock_frequency, input int baud_rate);
    return ticks_per_bit(clock_frequency, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Power-of-2 circular byte buffer with first-word-fall-through read port.
// One slot is sacrificed so that full and empty are distinguishable.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int Depth = 16,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AddrW = (Depth > 2) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] head;
  logic [AddrW-1:0] tail;
  logic [AddrW-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap naturally because the address width is exactly log2(Depth).
  assign head_next = head + 1'b1;
  assign full      = (head_next == tail);
  assign empty     = (head == tail);
  assign head_data = mem[tail];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_push) head <= head_next;
      if (do_pop)  tail <= tail + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[head] <= push_data;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, feeding a FWFT byte FIFO and
// reporting framing errors and overruns as single-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int BufferSize     = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_data,
  input  logic       i_read,
  output logic [7:0] o_frame,
  output logic       o_valid,
  output logic       o_frame_error,
  output logic       o_overrun
);

  localparam int TicksPerBit = ticks_per_bit(ClockFrequency, BaudRate);
  localparam int HalfBit     = half_bit(ClockFrequency, BaudRate);
  localparam int CntW        = (TicksPerBit > 1) ? $clog2(TicksPerBit) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(TicksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);

  logic            sync1;
  logic            sync2;
  logic            prev;
  logic [1:0]      state;
  logic [CntW-1:0] tick;
  logic [2:0]      bit_idx;
  logic [7:0]      sr;
  logic            frame_error;
  logic            overrun;
  logic            fifo_full;
  logic            fifo_empty;
  logic            stop_sample;
  logic            push;

  assign stop_sample = (state == ST_STOP) && (tick == BitLast);
  assign push        = stop_sample && sync2 && !fifo_full;

  // Full is taken before any same-cycle pop, so a pop cannot rescue a byte
  // arriving into a full buffer.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      state       <= ST_IDLE;
      tick        <= '0;
      bit_idx     <= '0;
      sr          <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync1       <= i_data;
      sync2       <= sync1;
      prev        <= sync2;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        ST_IDLE: begin
          tick    <= '0;
          bit_idx <= '0;
          if (prev && !sync2) state <= ST_START;
        end
        ST_START: begin
          if (tick == HalfLast) begin
            tick  <= '0;
            state <= sync2 ? ST_IDLE : ST_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick == BitLast) begin
            tick    <= '0;
            sr      <= {sync2, sr[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick == BitLast) begin
            tick  <= '0;
            state <= ST_IDLE;
            if (!sync2)         frame_error <= 1'b1;
            else if (fifo_full) overrun     <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_fifo #(
    .Depth(BufferSize),
    .Width(8)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST),
    .push     (push),
    .push_data(sr),
    .pop      (i_read),
    .head_data(o_frame),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign o_valid       = !fifo_empty;
  assign o_frame_error = frame_error;
  assign o_overrun     = overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver predicts each frame's outcome
// from the 8N1 rules and a buffer-occupancy count; a monitor pops and checks.
module tb_uart_rx;

  localparam int ClockFrequency = 1_000_000;
  localparam int BaudRate       = 100_000;
  localparam int BufferSize     = 4;
  localparam int BitCycles      = ClockFrequency / BaudRate;
  localparam int FlagFrame      = 1;
  localparam int FlagOverrun    = 2;

  logic       clk;
  logic       rst;
  logic       i_data;
  logic       i_read;
  logic [7:0] o_frame;
  logic       o_valid;
  logic       o_frame_error;
  logic       o_overrun;

  int total = 0;
  int bad   = 0;
  int read_mode = 0;
  int model_count = 0;
  int exp_bytes[$];
  int exp_flags[$];

  uart_rx #(
    .ClockFrequency(ClockFrequency),
    .BaudRate      (BaudRate),
    .BufferSize    (BufferSize)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .i_data       (i_data),
    .i_read       (i_read),
    .o_frame      (o_frame),
    .o_valid      (o_valid),
    .o_frame_error(o_frame_error),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Predict the outcome from the frame itself and the number of bytes held.
  task automatic applyStimulus(input logic [7:0] data, input logic stop, input int gap);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    if (!stop) exp_flags.push_back(FlagFrame);
    else if (model_count == BufferSize - 1) exp_flags.push_back(FlagOverrun);
    else begin
      exp_bytes.push_back(int'(data));
      model_count++;
    end
    for (int i = 0; i < 10; i++) begin
      i_data = bits[i];
      repeat (BitCycles) @(negedge clk);
    end
    i_data = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drainAll(input string name);
    read_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if (exp_bytes.size() == 0 && !o_valid) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checkOutput({name, "_pending"}, exp_bytes.size(), 0);
    checkOutput({name, "_valid"}, int'(o_valid), 0);
  endtask

  // Monitor / consumer: checks every byte as it is popped and every flag pulse.
  initial begin : monitor
    int e;
    bit want;
    i_read = 1'b0;
    forever begin
      @(negedge clk);
      i_read = 1'b0;
      if (rst) begin
        if (o_frame_error) begin
          e = (exp_flags.size() != 0) ? exp_flags.pop_front() : 0;
          checkOutput("frame_error_pulse", FlagFrame, e);
        end
        if (o_overrun) begin
          e = (exp_flags.size() != 0) ? exp_flags.pop_front() : 0;
          checkOutput("overrun_pulse", FlagOverrun, e);
        end
        if (o_valid) begin
          want = (read_mode == 1) || (read_mode == 2 && $urandom_range(0, 1) == 1);
          if (want) begin
            e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : -1;
            checkOutput("rx_byte", int'(o_frame), e);
            if (model_count > 0) model_count--;
            i_read = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] rnd;
    logic       stp;
    rst = 1'b0;
    i_data = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", int'(o_valid), 0);
    checkOutput("reset_frame_error", int'(o_frame_error), 0);
    checkOutput("reset_overrun", int'(o_overrun), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] single frame");
    read_mode = 0;
    applyStimulus(8'hA5, 1'b1, 0);
    checkOutput("single_valid", int'(o_valid), 1);
    checkOutput("single_frame", int'(o_frame), 8'hA5);
    read_mode = 1;
    repeat (3) @(negedge clk);
    checkOutput("single_after_pop", int'(o_valid), 0);
    drainAll("single");

    $display("[TB] glitch");
    i_data = 1'b0;
    repeat (3) @(negedge clk);
    i_data = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch_valid", int'(o_valid), 0);
    applyStimulus(8'h5A, 1'b1, 5);
    drainAll("after_glitch");

    $display("[TB] framing error");
    applyStimulus(8'h3C, 1'b0, 20);
    checkOutput("ferr_valid", int'(o_valid), 0);
    applyStimulus(8'h11, 1'b1, 5);
    drainAll("after_ferr");

    $display("[TB] overrun");
    read_mode = 0;
    applyStimulus(8'h01, 1'b1, 0);
    applyStimulus(8'h02, 1'b1, 0);
    applyStimulus(8'h03, 1'b1, 0);
    applyStimulus(8'h04, 1'b1, 5);
    checkOutput("overrun_held", exp_bytes.size(), 3);
    checkOutput("overrun_valid", int'(o_valid), 1);
    drainAll("overrun");

    $display("[TB] back-to-back with reads");
    read_mode = 1;
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    applyStimulus(8'h55, 1'b1, 5);
    drainAll("b2b");

    $display("[TB] reset mid-frame");
    read_mode = 0;
    applyStimulus(8'h77, 1'b1, 5);
    i_data = 1'b0;
    repeat (BitCycles) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      i_data = (i % 2 == 0);
      repeat (BitCycles) @(negedge clk);
    end
    i_data = 1'b0;
    repeat (BitCycles / 2) @(negedge clk);
    rst = 1'b0;
    i_data = 1'b1;
    exp_bytes.delete();
    exp_flags.delete();
    model_count = 0;
    repeat (3) @(negedge clk);
    checkOutput("midreset_valid", int'(o_valid), 0);
    checkOutput("midreset_frame_error", int'(o_frame_error), 0);
    checkOutput("midreset_overrun", int'(o_overrun), 0);
    rst = 1'b1;
    repeat (120) @(negedge clk);
    checkOutput("post_reset_empty", int'(o_valid), 0);
    read_mode = 1;
    applyStimulus(8'hC3, 1'b1, 5);
    drainAll("after_reset");

    $display("[TB] random frames");
    read_mode = 2;
    for (int n = 0; n < 20; n++) begin
      rnd = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 5) != 0);
      applyStimulus(rnd, stp, stp ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12)));
    end
    repeat (20) @(negedge clk);
    drainAll("random");
    checkOutput("flags_outstanding", exp_flags.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Simplex UART receiver, the inbound counterpart of the FPGA's UART transmitter. It recovers 8N1 frames from an asynchronous serial line using mid-bit sampling. Received bytes are buffered in a power-of-2 circular FIFO and presented to the consumer through a first-word-fall-through valid/read handshake. It flags framing errors and buffer overruns.

## Interface
- ClockFrequency, 50_000_000: CLK frequency in Hz.
- BaudRate, 115200: serial bit rate.
- BufferSize, 16: FIFO depth; must be a power of 2. Usable capacity is BufferSize-1.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-low.
- i_data  in  1  asynchronous serial line, idle high.
- i_read  in  1  consumer pop; honoured only when o_valid=1.
- o_frame  out  8  FIFO head byte; valid while o_valid=1.
- o_valid  out  1  FIFO non-empty.
- o_frame_error  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: good frame dropped because FIFO full.

## Operation
- TicksPerBit = ClockFrequency/BaudRate (integer divide). HalfBit = TicksPerBit/2.
- Line synchronizer: 2-flop chain on i_data, both reset to 1. A third register holds the previous synced value for edge detection.
- FSM states: IDLE, START, DATA, STOP. The tick counter is cleared on every state change.
- IDLE: on synced falling edge (prev=1, cur=0), go to START.
- START: at tick HalfBit-1, sample the line.
  - 0: go to DATA.
  - 1: glitch; go to IDLE, no flags.
- DATA:
  - Every TicksPerBit ticks, sample the line and shift it in LSB-first (sr <= {line, sr[7:1]}).
  - Increment the bit counter (0..7).
  - After bit 7, go to STOP.
- STOP: after TicksPerBit ticks, sample the line.
  - 1 and FIFO not full: write sr at head, head+1.
  - 1 and FIFO full: pulse o_overrun; byte discarded.
  - 0: pulse o_frame_error; byte discarded.
  - In all cases, go to IDLE. A low line after an error does not restart reception until it returns high; an edge is required.
- FIFO:
  - Full when head+1 == tail (wraps modulo BufferSize). o_valid = (head != tail). o_frame = buffer[tail].
  - i_read && o_valid: tail+1.
  - Full is evaluated on the pre-pop state. A push and a pop in the same cycle while full still overruns.
  - Push and pop in the same cycle when not full: both take effect.
- Reset mid-operation:
  - FSM returns to IDLE; counters, head and tail are cleared; stored bytes are lost; synchronizer is set to 1.
  - A frame already in progress on the line is ignored until the next falling edge.

## Timing
- Reset values: o_valid=0, o_frame_error=0, o_overrun=0. o_frame is don't-care while o_valid=0.
- Start detection latency: 3 cycles after the i_data fall (2 sync + edge register).
- Sample points: HalfBit-1 ticks into START, then every TicksPerBit ticks, so each sample lands at mid-bit.
- o_valid rises 1 cycle after the STOP sample cycle. The flag pulses are asserted in the same cycle o_valid would rise.
- Pop: o_frame updates to the next entry 1 cycle after i_read is accepted.
- Baud tolerance: approximately ±4% cumulative over 10 bits. Back-to-back frames (stop bit immediately followed by start) are received with no gap.

## Structure
- Shared package uart_pkg:
  - FrameWidth=10.
  - TicksPerBit/HalfBit constant functions.
  - FSM state encoding. The transmitter uses the same constants.
- Sub-module uart_fifo: circular buffer (BufferSize, 8-bit) with push/pop/full/empty and FWFT output. Reusable by the transmitter.

## Test plan
Sim parameters: ClockFrequency=1_000_000, BaudRate=100_000 (TicksPerBit=10), BufferSize=4.
- Single frame: drive 0xA5 8N1 -> o_valid rises about 98 cycles after the start edge with o_frame=0xA5. Pulse i_read -> o_valid=0 next cycle.
- Glitch: hold i_data low for 3 cycles, then high -> no o_valid, no flags, FSM back in IDLE.
- Framing error: send 0x3C with a stop bit of 0 -> o_frame_error pulses for 1 cycle, o_valid stays 0. The next valid frame 0x11 is received correctly.
- Overrun: send 0x01, 0x02, 0x03, 0x04 back-to-back with no reads -> 3 bytes stored and o_overrun pulses on the 4th. Reads return 0x01, 0x02, 0x03, then o_valid=0.
- Back-to-back with concurrent reads: stream 0x00, 0xFF, 0x55 while popping every byte -> all three are received in order, no flags.
- Reset mid-frame: assert RST during DATA bit 4 -> outputs at reset values, FIFO empty. The subsequent frame 0xC3 is received correctly.
